// File: rtl/sne_evt_stream_pkg.sv
// sne_evt_stream_pkg: shared FSM encoding and tap-index sizing for the event kernel sequencer
package sne_evt_stream_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_SYNC, ST_ARMED, ST_RUN, ST_DRAIN} seq_state_e;
  function automatic int tap_idx_width(input int max_radius);
    return $clog2((2 * max_radius + 1) ** 2);
  endfunction
endpackage

// File: rtl/evt_bounded_counter.sv
// evt_bounded_counter: signed up-counter sweeping -bound..+bound, wrapping back to -bound
module evt_bounded_counter #(
  parameter int BW = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load,
  input  logic              step,
  input  logic [BW-1:0]     load_bound,
  input  logic [BW-1:0]     bound,
  output logic signed [BW:0] value,
  output logic              done
);
  localparam logic signed [BW:0] ONE = 1;
  logic signed [BW:0] bound_s;
  logic wrap;
  assign bound_s = $signed({1'b0, bound});
  assign wrap = value == bound_s;
  assign done = step & wrap;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) value <= '0;
    else if (clear) value <= '0;
    else if (load) value <= -$signed({1'b0, load_bound});
    else if (step) value <= wrap ? -bound_s : value + ONE;
endmodule

// File: rtl/evt_kernel_sequencer.sv
// evt_kernel_sequencer: walks a (2r+1)^2 kernel around each spike, emitting per-group
// state-memory read taps and a one-cycle-delayed write-back.
module evt_kernel_sequencer
  import sne_evt_stream_pkg::*;
#(
  parameter int STREAM_ADDR_WIDTH = 16,
  parameter int SEQ_ADDR_WIDTH    = 6,
  parameter int NEURON_GROUP      = 16,
  parameter int MAX_RADIUS        = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic init_i,
  input  logic clear_i,
  input  logic time_stable_i,
  input  logic enable_i,
  input  logic evt_valid_i,
  output logic evt_ready_o,
  input  logic [STREAM_ADDR_WIDTH-1:0] evt_id_i,
  input  logic [$clog2(MAX_RADIUS+1)-1:0] radius_i,
  input  logic [NEURON_GROUP-1:0][STREAM_ADDR_WIDTH/2-1:0] lbound_y_i,
  input  logic [NEURON_GROUP-1:0][STREAM_ADDR_WIDTH/2-1:0] lbound_x_i,
  input  logic step_grant_i,
  output logic rd_valid_o,
  output logic [NEURON_GROUP-1:0][SEQ_ADDR_WIDTH-1:0] rd_addr_o,
  output logic [NEURON_GROUP-1:0] rd_mask_o,
  output logic [NEURON_GROUP-1:0][SEQ_ADDR_WIDTH-1:0] wr_addr_o,
  output logic [NEURON_GROUP-1:0] wr_en_o,
  output logic [tap_idx_width(MAX_RADIUS)-1:0] tap_idx_o,
  output logic done_o,
  output logic busy_o
);
  localparam int H  = STREAM_ADDR_WIDTH / 2;
  localparam int S  = SEQ_ADDR_WIDTH / 2;
  localparam int RW = $clog2(MAX_RADIUS + 1);
  localparam int TW = tap_idx_width(MAX_RADIUS);
  seq_state_e state, state_nxt;
  logic [STREAM_ADDR_WIDTH-1:0] ev_id;
  logic [RW-1:0] r, r_clamp;
  logic signed [RW:0] dy, dx;
  logic [RW:0] dy_off, dx_off;
  logic run, accept, step, dx_done, dy_done;
  logic [NEURON_GROUP-1:0] mask;
  logic [NEURON_GROUP-1:0][SEQ_ADDR_WIDTH-1:0] addr;

  assign run     = state == ST_RUN;
  assign accept  = (state == ST_ARMED) & evt_valid_i & ~clear_i;
  assign step    = run & enable_i & step_grant_i;
  assign r_clamp = radius_i > RW'(MAX_RADIUS) ? RW'(MAX_RADIUS) : radius_i;

  // dy only advances when dx wraps; the sweep ends when both wrap together
  evt_bounded_counter #(.BW(RW)) u_dx (
    .clk(clk_i), .rst_n(rst_ni), .clear(clear_i), .load(accept), .step(step),
    .load_bound(r_clamp), .bound(r), .value(dx), .done(dx_done)
  );
  evt_bounded_counter #(.BW(RW)) u_dy (
    .clk(clk_i), .rst_n(rst_ni), .clear(clear_i), .load(accept), .step(dx_done),
    .load_bound(r_clamp), .bound(r), .value(dy), .done(dy_done)
  );

  // relative coordinates keep two extra bits so negatives and overflow are range-checked intact
  for (genvar g = 0; g < NEURON_GROUP; g++) begin : g_grp
    logic signed [H+1:0] row_rel, col_rel;
    assign row_rel = $signed({2'b00, ev_id[STREAM_ADDR_WIDTH-1:H]}) + (H+2)'(dy)
                   - $signed({2'b00, lbound_y_i[g]});
    assign col_rel = $signed({2'b00, ev_id[H-1:0]}) + (H+2)'(dx)
                   - $signed({2'b00, lbound_x_i[g]});
    assign mask[g] = ~|row_rel[H+1:S] & ~|col_rel[H+1:S];
    assign addr[g] = {row_rel[S-1:0], col_rel[S-1:1], row_rel[0] ^ col_rel[0]};
  end

  assign dy_off    = dy + $signed({1'b0, r});
  assign dx_off    = dx + $signed({1'b0, r});
  assign rd_mask_o = run ? mask : '0;
  assign rd_addr_o = run ? addr : '0;
  assign tap_idx_o = run ? TW'(dy_off) * TW'({r, 1'b1}) + TW'(dx_off) : '0;

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state     <= ST_IDLE;
      ev_id     <= '0;
      r         <= '0;
      wr_addr_o <= '0;
      wr_en_o   <= '0;
    end else begin
      state   <= state_nxt;
      wr_en_o <= step & ~clear_i ? rd_mask_o : '0;
      if (step) wr_addr_o <= rd_addr_o;
      if (accept) begin
        ev_id <= evt_id_i;
        r     <= r_clamp;
      end
    end

  always_comb begin
    state_nxt   = state;
    evt_ready_o = state == ST_ARMED;
    rd_valid_o  = run & enable_i;
    done_o      = state == ST_DRAIN;
    busy_o      = run | (state == ST_DRAIN);
    case (state)
      ST_IDLE:  state_nxt = init_i ? ST_SYNC : ST_IDLE;
      ST_SYNC:  state_nxt = time_stable_i ? ST_ARMED : ST_SYNC;
      ST_ARMED: state_nxt = evt_valid_i ? ST_RUN : ST_ARMED;
      ST_RUN:   state_nxt = dy_done ? ST_DRAIN : ST_RUN;
      ST_DRAIN: state_nxt = ST_ARMED;
      default:  state_nxt = ST_IDLE;
    endcase
    if (clear_i) state_nxt = ST_IDLE;
  end
endmodule

// File: tb/tb_evt_kernel_sequencer.sv
// tb_evt_kernel_sequencer: directed events with a tap scoreboard checked by a separate monitor
module tb_evt_kernel_sequencer;
  localparam int NG = 16;
  typedef struct packed {
    logic [4:0] tap;
    logic [NG-1:0] mask;
    logic [NG-1:0][5:0] addr;
  } exp_t;

  logic clk = 0, rst_n = 0, init = 0, clear = 0, tstable = 0, enable = 0, evt_valid = 0, grant = 0;
  logic evt_ready, rd_valid, done, busy;
  logic [15:0] evt_id = '0;
  logic [1:0] radius = '0;
  logic [NG-1:0][7:0] lby = '0, lbx = '0;
  logic [NG-1:0][5:0] rd_addr, wr_addr;
  logic [NG-1:0] rd_mask, wr_en;
  logic [4:0] tap_idx;
  int checks = 0, errors = 0, step_cnt = 0, wr_cnt = 0, last_tap = -1, ncyc;
  exp_t sbq[$];
  logic exp_wr_valid = 0;
  logic [NG-1:0] exp_wr_mask = '0;
  logic [NG-1:0][5:0] exp_wr_addr = '0;

  always #5 clk = ~clk;

  evt_kernel_sequencer dut (
    .clk_i(clk), .rst_ni(rst_n), .init_i(init), .clear_i(clear), .time_stable_i(tstable),
    .enable_i(enable), .evt_valid_i(evt_valid), .evt_ready_o(evt_ready), .evt_id_i(evt_id),
    .radius_i(radius), .lbound_y_i(lby), .lbound_x_i(lbx), .step_grant_i(grant),
    .rd_valid_o(rd_valid), .rd_addr_o(rd_addr), .rd_mask_o(rd_mask), .wr_addr_o(wr_addr),
    .wr_en_o(wr_en), .tap_idx_o(tap_idx), .done_o(done), .busy_o(busy)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // reference: every tap of the kernel in raster order, computed with plain integers
  task automatic push_event(input int row, input int col, input int r);
    for (int dy = -r; dy <= r; dy++)
      for (int dx = -r; dx <= r; dx++) begin
        exp_t e;
        e.tap = 5'((dy + r) * (2 * r + 1) + (dx + r));
        for (int g = 0; g < NG; g++) begin
          int rr, cr;
          rr = row + dy - int'(lby[g]);
          cr = col + dx - int'(lbx[g]);
          e.mask[g] = rr >= 0 && rr < 8 && cr >= 0 && cr < 8;
          e.addr[g] = {3'(rr), 2'(cr >>> 1), 1'(rr ^ cr)};
        end
        sbq.push_back(e);
      end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst_n) exp_wr_valid = 0;
    else begin
      check("wr_en", wr_en, exp_wr_valid ? exp_wr_mask : '0);
      if (exp_wr_valid && exp_wr_mask != 0) check("wr_addr", wr_addr, exp_wr_addr);
      if (wr_en != 0) wr_cnt++;
      exp_wr_valid = 0;
      if (rd_valid && grant) begin
        step_cnt++;
        last_tap = int'(tap_idx);
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow got tap=%0d expected no step", tap_idx);
        end else begin
          e = sbq.pop_front();
          check("tap_idx", tap_idx, e.tap);
          check("rd_mask", rd_mask, e.mask);
          check("rd_addr", rd_addr, e.addr);
          exp_wr_valid = !clear;
          exp_wr_mask  = e.mask;
          exp_wr_addr  = e.addr;
        end
      end
    end
  end

  task automatic wait_ready(input string name);
    int n = 0;
    @(posedge clk); #1;
    while (!evt_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, evt_ready, 1'b1);
  endtask

  task automatic do_init();
    @(posedge clk); #1 init = 1; tstable = 1;
    @(posedge clk); #1 init = 0;
    wait_ready("init_ready");
  endtask

  task automatic send_event(input logic [15:0] id, input logic [1:0] rad, input int r_exp);
    push_event(int'(id[15:8]), int'(id[7:0]), r_exp);
    wait_ready("ev_ready");
    evt_id = id; radius = rad; evt_valid = 1;
    @(posedge clk); #1 evt_valid = 0; evt_id = 16'($urandom);
  endtask

  task automatic wait_done(input bit toggle, input string name, output int n);
    bit seen = 0;
    n = 0;
    while (!seen && n < 100) begin
      if (toggle) enable = ~enable;
      @(negedge clk);
      seen = done;
      n++;
      if (!seen) begin @(posedge clk); #1; end
    end
    check(name, seen, 1'b1);
  endtask

  task automatic set_lb(input int y, input int x);
    for (int g = 0; g < NG; g++) begin lby[g] = 8'(y); lbx[g] = 8'(x); end
  endtask

  initial begin
    grant = 1; enable = 1; tstable = 1;
    repeat (2) @(posedge clk); #1;
    check("rst_ready", evt_ready, 1'b0);
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_busy", {done, busy}, 2'b00);
    check("rst_wr_en", wr_en, '0);
    check("rst_mask", rd_mask, '0);
    check("rst_addr", {rd_addr, wr_addr}, '0);
    check("rst_tap", tap_idx, '0);
    rst_n = 1;
    repeat (3) begin @(posedge clk); #1; end
    check("idle_no_init", evt_ready, 1'b0);

    // r=1 around {10,10}, all groups at origin 8: nine fully in-range taps
    set_lb(8, 8);
    do_init();
    step_cnt = 0; wr_cnt = 0;
    send_event(16'h0A0A, 2'd1, 1);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check("t1_first_addr", rd_addr[0], 6'd8);
        check("t1_first_mask", rd_mask, 16'hFFFF);
      end
      check("t1_done", done, c == 10);
      check("t1_wr_en", wr_en, (c >= 2 && c <= 10) ? 16'hFFFF : 16'h0000);
      check("t1_busy", busy, c <= 10);
    end
    check("t1_rearm", evt_ready, 1'b1);
    check("t1_steps", step_cnt, 9);
    check("t1_last_tap", last_tap, 8);

    // r=2 at the corner {0,0}: only dy>=0, dx>=0 taps land
    set_lb(0, 0);
    step_cnt = 0; wr_cnt = 0;
    send_event(16'h0000, 2'd2, 2);
    wait_done(0, "t2_done", ncyc);
    @(negedge clk);
    check("t2_cycles", ncyc, 26);
    check("t2_writes", wr_cnt, 9);
    check("t2_steps", step_cnt, 25);

    // enable toggling with grant held: counters advance only on enabled cycles
    set_lb(8, 8);
    enable = 0;
    step_cnt = 0; wr_cnt = 0;
    send_event(16'h0A0A, 2'd1, 1);
    wait_done(1, "t3_done", ncyc);
    @(negedge clk);
    check("t3_cycles", ncyc, 18);
    check("t3_steps", step_cnt, 9);
    check("t3_writes", wr_cnt, 9);
    enable = 1;

    // radius 3 clamps to 2; per-group origins spread the masks
    for (int g = 0; g < NG; g++) begin lby[g] = 8'(g); lbx[g] = 8'(15 - g); end
    step_cnt = 0;
    send_event(16'h0C0D, 2'd3, 2);
    wait_done(0, "t4_done", ncyc);
    @(negedge clk);
    check("t4_cycles", ncyc, 26);
    check("t4_steps", step_cnt, 25);
    check("t4_last_tap", last_tap, 24);

    // clear on the 4th step drops the write and the event
    set_lb(8, 8);
    step_cnt = 0;
    send_event(16'h0A0A, 2'd1, 1);
    repeat (3) begin @(posedge clk); #1; end
    clear = 1;
    @(posedge clk); #1 clear = 0;
    @(negedge clk);
    check("t5_wr_en", wr_en, '0);
    check("t5_busy", busy, 1'b0);
    check("t5_ready", evt_ready, 1'b0);
    check("t5_steps", step_cnt, 4);
    sbq.delete();
    repeat (4) begin @(posedge clk); #1; end
    check("t5_idle", evt_ready, 1'b0);
    do_init();

    // r=0 back-to-back without re-init
    set_lb(0, 0);
    step_cnt = 0;
    send_event(16'h0303, 2'd0, 0);
    @(negedge clk);
    check("t6_tap", tap_idx, 5'd0);
    check("t6_busy", busy, 1'b1);
    @(negedge clk);
    check("t6_done", done, 1'b1);
    @(negedge clk);
    check("t6_rearm", evt_ready, 1'b1);
    send_event(16'h0505, 2'd0, 0);
    wait_done(0, "t6_done2", ncyc);
    check("t6_cycles2", ncyc, 2);
    check("t6_steps", step_cnt, 2);

    // async reset mid-run drops the event; init is required again
    send_event(16'h0404, 2'd2, 2);
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 0;
    #1;
    check("t7_busy", {busy, rd_valid, evt_ready}, 3'b000);
    check("t7_wr_en", wr_en, '0);
    sbq.delete();
    @(posedge clk); #1 rst_n = 1;
    wr_cnt = 0;
    repeat (4) begin @(posedge clk); #1; end
    check("t7_no_rearm", evt_ready, 1'b0);
    check("t7_no_writes", wr_cnt, 0);
    do_init();
    send_event(16'h0101, 2'd0, 0);
    wait_done(0, "t7_done", ncyc);
    @(negedge clk);
    check("sb_drained", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/evt_kernel_sequencer.md
EVT_KERNEL_SEQUENCER -- requirements
Module: evt_kernel_sequencer

Interface
REQ-001 SHALL have parameter STREAM_ADDR_WIDTH, default 16: event ID width, {row,col} halves of H=STREAM_ADDR_WIDTH/2 bits.
REQ-002 SHALL have parameter SEQ_ADDR_WIDTH, default 6: per-group state-memory address width, S=SEQ_ADDR_WIDTH/2 bits per axis.
REQ-003 SHALL have parameter NEURON_GROUP, default 16: number of neuron groups addressed in parallel.
REQ-004 SHALL have parameter MAX_RADIUS, default 2: largest kernel radius; max kernel is (2*MAX_RADIUS+1) squared taps.
REQ-005 SHALL have one clock and an asynchronous active-low reset: clk_i  in  1  clock; rst_ni  in  1  async active-low reset.
REQ-006 SHALL have ports: init_i in 1 arm request; clear_i in 1 sync abort; time_stable_i in 1 time-base settled; enable_i in 1 step gate.
REQ-007 SHALL have ports: evt_valid_i in 1; evt_ready_o out 1; evt_id_i in STREAM_ADDR_WIDTH spike {row,col}; radius_i in RW=$clog2(MAX_RADIUS+1) kernel radius.
REQ-008 SHALL have ports: lbound_y_i, lbound_x_i in NEURON_GROUP x H group origin.
REQ-009 SHALL have ports: step_grant_i in 1 downstream accepts current tap; rd_valid_o out 1; rd_addr_o out NEURON_GROUP x SEQ_ADDR_WIDTH; rd_mask_o out NEURON_GROUP.
REQ-010 SHALL have ports: wr_addr_o out NEURON_GROUP x SEQ_ADDR_WIDTH; wr_en_o out NEURON_GROUP; tap_idx_o out $clog2((2*MAX_RADIUS+1)**2) tap index; done_o out 1; busy_o out 1.

Function
REQ-011 SHALL implement FSM IDLE, SYNC, ARMED, RUN, DRAIN; reset state IDLE.
REQ-012 IDLE: init_i -> SYNC. SYNC: time_stable_i -> ARMED, else stay in SYNC.
REQ-013 ARMED: evt_ready_o=1; on evt_valid_i & evt_ready_o latch evt_id_i and r=min(radius_i,MAX_RADIUS), set dy=dx=-r, go RUN.
REQ-014 evt_ready_o SHALL be 1 only in ARMED; evt_id_i is ignored in all other states.
REQ-015 RUN: rd_valid_o=enable_i; a step occurs on step_grant_i & enable_i & rd_valid_o.
REQ-016 On a step: dx increments; when dx==+r, dx wraps to -r and dy increments; a step at (dy,dx)=(+r,+r) moves to DRAIN.
REQ-017 step_grant_i without enable_i SHALL not advance the counters.
REQ-018 Per group g: row_rel=ev_row+dy-lbound_y_i[g], col_rel=ev_col+dx-lbound_x_i[g]; both signed, H+2 bits, no truncation before the range check.
REQ-019 rd_mask_o[g]=1 iff 0<=row_rel<2**S and 0<=col_rel<2**S.
REQ-020 rd_addr_o[g]={row_rel[S-1:0], col_rel[S-1:1], row_rel[0]^col_rel[0]} (bank-interleaved), combinational from the current tap.
REQ-021 tap_idx_o=(dy+r)*(2r+1)+(dx+r), combinational.
REQ-022 Write path SHALL be one-cycle delayed: the cycle after a step, wr_addr_o holds the registered rd_addr_o and wr_en_o holds the registered rd_mask_o of the stepped tap; otherwise wr_en_o=0.
REQ-023 DRAIN lasts exactly one cycle: the final write occurs, done_o=1 for one cycle, then ARMED, so back-to-back events need no re-init.
REQ-024 r=0 SHALL give a single tap: RUN, then DRAIN after one step.
REQ-025 clear_i SHALL force IDLE next cycle from any state, with wr_en_o=0 next cycle even if a step coincides; clear_i takes priority over all other inputs.
REQ-026 busy_o=1 in RUN and DRAIN.

Reset
REQ-027 Async reset SHALL give: state IDLE, dy=dx=0, r=0, latched ID 0, write registers 0; all outputs 0 (evt_ready_o, rd_valid_o, wr_en_o, done_o, busy_o, rd_mask_o, addresses, tap_idx_o).
REQ-028 Reset mid-RUN SHALL drop the event with no further writes; the next event requires init_i.

Structure
REQ-029 FSM state enum and the tap-index width function SHALL live in sne_evt_stream_pkg.
REQ-030 The signed up-counter with runtime bound, wrap and done SHALL be sub-module evt_bounded_counter, instantiated twice (dx, dy).

Verification
REQ-031 r=1, id {10,10}, lbound 8 all groups, grant every cycle: 9 steps, tap_idx 0..8, wr_en all-ones on cycles 2..10, done_o on cycle 10.
REQ-032 r=2, id {0,0}, lbound 0: taps with dy<0 or dx<0 give rd_mask_o=0 and wr_en_o=0; 9 of 25 taps write.
REQ-033 r=1, grant held 1 with enable_i toggling 1,0,1,...: tap advances only on enable cycles; 9 writes total.
REQ-034 radius_i=3 with MAX_RADIUS=2: clamped, 25 taps, last tap_idx 24.
REQ-035 clear_i asserted on the 4th step of r=1: no wr_en_o the next cycle, FSM in IDLE, evt_ready_o=0 until init_i and time_stable_i.
REQ-036 Two events back-to-back (r=0): done_o, then evt_ready_o=1 the next cycle, second event accepted without init_i.
